lcd_read: RTL and testbench

- Read-side companion to the LCD init/transfer path on the HD44780-style 4-bit bus.
- Performs one RW=1 read cycle as two nibble strobes, high nibble first, and assembles the byte.
- Reads either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1).
- Optional poll mode repeats BF/AC reads until BF clears or a limit is reached, so command sequencing can wait on the real busy flag instead of fixed delays.

---
 rtl/lcd_read.sv | 159 +++++++++++++++
 tb/tb_lcd_read.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lcd_read.sv
// lcd_read: one HD44780 4-bit read transaction (RW=1), high nibble first.
// Reads BF/AC (rs=0) or a data byte (rs=1). With poll=1 and rs=0 the BF/AC
// read repeats, bus held, until BF clears or MAX_POLLS reads have been made.
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   start, rs, poll request, accepted only while ready=1
//   LCD_D_in        LCD data nibble, sampled on the edge ending each E pulse
//   LCD_E/RW/RS     LCD control strobes
//   READ            1 = FPGA bus driver released (tracks LCD_RW)
//   ready           idle, can accept start
//   data_out        last assembled byte
//   busy_flag       bit 7 of the last BF/AC read
//   addr_counter    bits 6:0 of the last BF/AC read
//   valid           one-cycle result pulse
//   timeout         one-cycle pulse with valid when polling gave up on BF
module lcd_read #(
  parameter int FREQ      = 50000000,
  parameter int T_AS_CYC  = 3,
  parameter int T_PW_CYC  = 12,
  parameter int T_LOW_CYC = 13,
  parameter int T_H_CYC   = 1,
  parameter int MAX_POLLS = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       start,
  input  logic       rs,
  input  logic       poll,
  input  logic [3:0] LCD_D_in,
  output logic       LCD_E,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       READ,
  output logic       ready,
  output logic [7:0] data_out,
  output logic       busy_flag,
  output logic [6:0] addr_counter,
  output logic       valid,
  output logic       timeout
);

  localparam int MAX_AP = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
  localparam int MAX_LH = (T_LOW_CYC > T_H_CYC) ? T_LOW_CYC : T_H_CYC;
  localparam int MAXC   = (MAX_AP > MAX_LH) ? MAX_AP : MAX_LH;
  localparam int CW     = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] AS_LAST  = CW'(T_AS_CYC - 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(T_PW_CYC - 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(T_LOW_CYC - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(T_H_CYC - 1);

  if (MAX_POLLS < 1 || MAX_POLLS > 255 || FREQ <= 0 || MAXC < 1) begin : g_bad_param
    $error("lcd_read: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, E_HI1, E_LO, E_HI2, HOLD, FINISH} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [7:0]    poll_cnt, poll_inc;
  logic          rs_r, poll_r;
  logic          phase;      // 1 once the high nibble of the current read is in
  logic [3:0]    nib_hi, nib_lo;
  logic          accept, repeat_rd, finish_rd, idle_nxt;

  assign poll_inc = poll_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    repeat_rd = 1'b0;
    finish_rd = 1'b0;
    case (state)
      IDLE:   if (start && ready) begin
                state_nxt = SETUP;
                accept    = 1'b1;
              end
      SETUP:  if (cnt == AS_LAST)  state_nxt = E_HI1;
      E_HI1:  if (cnt == PW_LAST)  state_nxt = E_LO;
      E_LO:   if (cnt == LOW_LAST) state_nxt = phase ? E_HI2 : E_HI1;
      E_HI2:  if (cnt == PW_LAST)  state_nxt = HOLD;
      HOLD:   if (cnt == H_LAST)   state_nxt = FINISH;
      FINISH: begin
        // poll_inc already counts the read just finished
        if (poll_r && nib_hi[3] && (poll_inc < 8'(MAX_POLLS))) begin
          state_nxt = E_LO;
          repeat_rd = 1'b1;
        end else begin
          state_nxt = IDLE;
          finish_rd = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // ready stays low through the valid cycle (the one after FINISH)
    idle_nxt = (state_nxt == IDLE) && (state != FINISH);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      poll_cnt     <= '0;
      rs_r         <= 1'b0;
      poll_r       <= 1'b0;
      phase        <= 1'b0;
      nib_hi       <= '0;
      nib_lo       <= '0;
      LCD_E        <= 1'b0;
      LCD_RW       <= 1'b0;
      LCD_RS       <= 1'b0;
      READ         <= 1'b0;
      ready        <= 1'b1;
      data_out     <= '0;
      busy_flag    <= 1'b0;
      addr_counter <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;

      if (accept) begin
        rs_r     <= rs;
        poll_r   <= poll & ~rs;
        poll_cnt <= '0;
        phase    <= 1'b0;
        LCD_RS   <= rs;
      end
      if (state == E_HI1 && state_nxt == E_LO) begin
        nib_hi <= LCD_D_in;
        phase  <= 1'b1;
      end
      if (state == E_HI2 && state_nxt == HOLD)
        nib_lo <= LCD_D_in;
      if (repeat_rd) begin
        poll_cnt <= poll_inc;
        phase    <= 1'b0;
      end
      if (finish_rd) begin
        poll_cnt <= poll_inc;
        data_out <= {nib_hi, nib_lo};
        if (!rs_r) begin
          busy_flag    <= nib_hi[3];
          addr_counter <= {nib_hi[2:0], nib_lo};
        end
      end

      valid   <= finish_rd;
      timeout <= finish_rd & poll_r & nib_hi[3];
      LCD_E   <= (state_nxt == E_HI1) || (state_nxt == E_HI2);
      ready   <= idle_nxt;
      LCD_RW  <= ~idle_nxt;
      READ    <= ~idle_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_read.sv
// Bench for lcd_read: an LCD model serves nibbles during E-high windows and a
// transaction-level model predicts read count, result timing and outputs.
module tb_lcd_read;
  localparam int MAXP = 4;
  localparam int AS = 3, PW = 12, LOW = 13, H = 1;
  localparam int LAT1   = 1 + AS + 2*PW + LOW + H + 1;     // start edge -> valid
  localparam int PER_RD = LOW + 2*PW + LOW + H + 1;        // per extra poll read

  logic       CLK = 1'b0, RESET, start, rs, poll;
  logic [3:0] LCD_D_in;
  logic       LCD_E, LCD_RW, LCD_RS, READ, ready, valid, timeout, busy_flag;
  logic [7:0] data_out;
  logic [6:0] addr_counter;

  lcd_read #(.MAX_POLLS(MAXP)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .rs(rs), .poll(poll),
    .LCD_D_in(LCD_D_in), .LCD_E(LCD_E), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS),
    .READ(READ), .ready(ready), .data_out(data_out), .busy_flag(busy_flag),
    .addr_counter(addr_counter), .valid(valid), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // LCD model: byte i is served over E pulses 2i (high) and 2i+1 (low).
  logic [7:0] resp [MAXP];
  int   rise_q[$], fall_q[$];
  int   pidx;
  logic e_prev = 1'b0;
  always @(negedge CLK) begin
    if (LCD_E && !e_prev) begin
      pidx = rise_q.size();
      rise_q.push_back(cyc);
      if (pidx / 2 < MAXP)
        LCD_D_in = (pidx % 2 == 0) ? resp[pidx/2][7:4] : resp[pidx/2][3:0];
      else
        LCD_D_in = 4'hF;
    end else if (!LCD_E && e_prev) begin
      fall_q.push_back(cyc);
      LCD_D_in = 4'($urandom);
    end
    e_prev = LCD_E;
  end

  // expected architectural state
  logic [7:0] m_data = 8'h00;
  logic       m_bf   = 1'b0;
  logic [6:0] m_ac   = 7'h00;

  task automatic run_txn(input logic r, input logic p, input bit hold_start);
    int k, t0, exp_v;
    bit to, got;
    k = 1; to = 0;
    if (!r && p)
      while (resp[k-1][7]) begin
        if (k == MAXP) begin to = 1; break; end
        k++;
      end
    exp_v = LAT1 + PER_RD * (k - 1);
    rise_q.delete(); fall_q.delete();
    rs = r; poll = p; start = 1'b1; t0 = cyc;
    @(negedge CLK);
    if (!hold_start) start = 1'b0;
    got = 0;
    for (int i = 0; i < exp_v + 20 && !got; i++) begin
      if (valid) got = 1;
      else begin
        check("bus_hold", {READ, LCD_RW, ready, LCD_RS, timeout}, {1'b1, 1'b1, 1'b0, r, 1'b0});
        @(negedge CLK);
      end
    end
    check("valid_seen", got, 1);
    if (!got) return;
    check("valid_cycle", cyc - t0, exp_v);
    check("data_out", data_out, resp[k-1]);
    check("timeout", timeout, to);
    check("ready_in_valid", {ready, LCD_RW, READ}, 3'b011);
    check("e_pulses", rise_q.size(), 2 * k);
    if (rise_q.size() > 0) check("first_rise", rise_q[0] - t0, 1 + AS);
    for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++)
      check("e_width", fall_q[i] - rise_q[i], PW);
    for (int i = 0; i + 1 < rise_q.size() && i < fall_q.size(); i++)
      check("e_low", rise_q[i+1] - fall_q[i], (i % 2 == 0) ? LOW : H + 1 + LOW);
    m_data = resp[k-1];
    if (!r) begin m_bf = resp[k-1][7]; m_ac = resp[k-1][6:0]; end
    check("busy_flag", busy_flag, m_bf);
    check("addr_counter", addr_counter, m_ac);
    @(negedge CLK);
    if (hold_start) start = 1'b0;
    check("release", {ready, LCD_RW, READ, valid, timeout}, 5'b10000);
  endtask

  task automatic fill(input int nbusy);
    for (int i = 0; i < MAXP; i++)
      resp[i] = (i < nbusy) ? (8'h80 | 8'($urandom)) : (8'h7F & 8'($urandom));
  endtask

  initial begin
    bit saw;
    RESET = 1'b1; start = 1'b0; rs = 1'b0; poll = 1'b0; LCD_D_in = 4'h0;
    for (int i = 0; i < MAXP; i++) resp[i] = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_ctrl", {LCD_E, LCD_RW, LCD_RS, READ, ready, valid, timeout}, 7'b0000100);
    check("rst_data", {data_out, busy_flag, addr_counter}, 16'h0000);
    RESET = 1'b0;
    @(negedge CLK);

    // data read
    resp[0] = 8'hA5;
    run_txn(1'b1, 1'b0, 0);
    // BF/AC read
    resp[0] = 8'h42;
    run_txn(1'b0, 1'b0, 0);
    // poll: three busy reads then 0x05
    resp[0] = 8'h8C; resp[1] = 8'hB1; resp[2] = 8'hFF; resp[3] = 8'h05;
    run_txn(1'b0, 1'b1, 0);
    // poll limit
    for (int i = 0; i < MAXP; i++) resp[i] = 8'hFF;
    run_txn(1'b0, 1'b1, 0);
    // handshake: start held through the valid cycle, then a new start right away
    resp[0] = 8'h3C;
    run_txn(1'b1, 1'b0, 1);
    resp[0] = 8'h17;
    run_txn(1'b0, 1'b0, 0);

    // reset during the first E-high window
    resp[0] = 8'h99;
    rs = 1'b1; poll = 1'b0; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    saw = 0;
    for (int i = 0; i < 20 && !saw; i++) begin
      if (LCD_E) saw = 1; else @(negedge CLK);
    end
    check("reset_e_seen", saw, 1);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_mid_ctrl", {LCD_E, LCD_RW, READ, ready, valid, timeout}, 6'b000100);
    check("rst_mid_data", {data_out, busy_flag, addr_counter}, 16'h0000);
    m_data = 8'h00; m_bf = 1'b0; m_ac = 7'h00;
    RESET = 1'b0;
    saw = 0;
    repeat (60) begin
      @(negedge CLK);
      if (valid || timeout || LCD_E || !ready) saw = 1;
    end
    check("rst_quiet", saw, 0);
    resp[0] = 8'h6E;
    run_txn(1'b1, 1'b0, 0);

    // randomized transactions
    for (int n = 0; n < 24; n++) begin
      fill($urandom_range(0, MAXP));
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
